// File: rtl/mux_pkg.sv
// Shared types and constants for the 4-lane round-robin arbiter and its data mux.
package mux_pkg;

  localparam int NUM_LANES = 4;
  localparam int SEL_W     = 2;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  typedef struct packed {
    state_t           state;
    logic [SEL_W-1:0] ptr;
  } arb_dbg_t;

  // Returns {found, lane}: the first requesting lane at or after ptr, wrapping modulo NUM_LANES.
  function automatic logic [SEL_W:0] rr_pick(input logic [NUM_LANES-1:0] valid,
                                             input logic [SEL_W-1:0]     ptr);
    logic [SEL_W:0]   res;
    logic [SEL_W-1:0] cand;
    res = '0;
    for (int k = NUM_LANES - 1; k >= 0; k--) begin
      cand = ptr + SEL_W'(k);
      if (valid[cand]) res = {1'b1, cand};
    end
    return res;
  endfunction

endpackage

// File: rtl/mux_4x1.sv
// Plain 4:1 data multiplexer, BITS wide.
module mux_4x1
  import mux_pkg::*;
#(
  parameter int BITS = 4
) (
  input  logic [BITS-1:0]  in0,
  input  logic [BITS-1:0]  in1,
  input  logic [BITS-1:0]  in2,
  input  logic [BITS-1:0]  in3,
  input  logic [SEL_W-1:0] sel,
  output logic [BITS-1:0]  out
);

  always_comb begin
    out = in0;
    case (sel)
      2'd0: out = in0;
      2'd1: out = in1;
      2'd2: out = in2;
      2'd3: out = in3;
      default: out = in0;
    endcase
  end

endmodule

// File: rtl/rr_arb_4x1.sv
// Four-lane round-robin arbiter feeding a single registered output slot.
// Handshake: a beat moves on any lane/port when valid and ready are both high at a rising edge.
module rr_arb_4x1
  import mux_pkg::*;
#(
  parameter int BITS = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [BITS-1:0]      in0,
  input  logic [BITS-1:0]      in1,
  input  logic [BITS-1:0]      in2,
  input  logic [BITS-1:0]      in3,
  input  logic [NUM_LANES-1:0] req_valid,
  output logic [NUM_LANES-1:0] req_ready,
  output logic [BITS-1:0]      out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [SEL_W-1:0]     out_sel,
  output arb_dbg_t             dbg
);

  state_t           state;
  logic [SEL_W-1:0] ptr;
  logic             slot_free;
  logic             gnt_found;
  logic [SEL_W-1:0] gnt_idx;
  logic [BITS-1:0]  mux_out;

  assign slot_free            = (state == EMPTY) || out_ready;
  assign {gnt_found, gnt_idx} = rr_pick(req_valid, ptr);

  // Gated by rst_n so no lane sees an accept while reset is asserted.
  always_comb begin
    req_ready = '0;
    if (rst_n && slot_free && gnt_found) req_ready[gnt_idx] = 1'b1;
  end

  mux_4x1 #(.BITS(BITS)) u_mux (
    .in0 (in0),
    .in1 (in1),
    .in2 (in2),
    .in3 (in3),
    .sel (gnt_idx),
    .out (mux_out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= EMPTY;
      ptr      <= '0;
      out_data <= '0;
      out_sel  <= '0;
    end else if (slot_free) begin
      if (gnt_found) begin
        state    <= FULL;
        out_data <= mux_out;
        out_sel  <= gnt_idx;
        ptr      <= gnt_idx + SEL_W'(1);
      end else begin
        state <= EMPTY;
      end
    end
  end

  assign out_valid = (state == FULL);
  assign dbg       = '{state: state, ptr: ptr};

endmodule
